// File: rtl/mult_div_if.sv
// Request/result bundle for the iterative multiply/divide unit.
interface mult_div_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide: sign-magnitude operands, shift-add multiply,
// restoring divide, sign correction on the final edge. Fixed WIDTH+1 cycle latency.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    mult_div_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINISH
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               dbz_lat;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;

    logic               busy_r;
    logic               done_r;
    logic               dbz_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand conditioning and one iteration step for either operation.
    always_comb begin
        a_neg     = bus.op[0] & bus.a[WIDTH-1];
        b_neg     = bus.op[0] & bus.b[WIDTH-1];
        abs_a     = a_neg ? WIDTH'(-bus.a) : bus.a;
        abs_b     = b_neg ? WIDTH'(-bus.b) : bus.b;

        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));

        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = WIDTH'(div_shift - {1'b0, opnd});

        if (is_div) begin
            step_acc = {(div_ge ? div_diff : div_shift[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
        end else begin
            step_acc = {mul_sum, acc[WIDTH-1:1]};
        end

        prod_fix  = neg_q ? (2*WIDTH)'(-acc) : acc;
        rem_fix   = neg_r ? WIDTH'(-acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        if (dbz_lat) begin
            quo_fix = '1;
        end else begin
            quo_fix = neg_q ? WIDTH'(-acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        end
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dbz_lat <= 1'b0;
            opnd    <= '0;
            acc     <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
            hi_r    <= '0;
            lo_r    <= '0;
        end else begin
            done_r <= 1'b0;
            dbz_r  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        is_div  <= bus.op[1];
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= bus.op[1] & a_neg;
                        dbz_lat <= bus.op[1] & (bus.b == '0);
                        opnd    <= bus.op[1] ? abs_b : abs_a;
                        acc     <= {WIDTH'(0), (bus.op[1] ? abs_a : abs_b)};
                        cnt     <= '0;
                        busy_r  <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    acc <= step_acc;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    // Divide by zero: quotient forced to all ones; remainder is |a| re-signed, i.e. a.
                    if (is_div) begin
                        hi_r  <= rem_fix;
                        lo_r  <= quo_fix;
                        dbz_r <= dbz_lat;
                    end else begin
                        hi_r <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix[WIDTH-1:0];
                    end
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit at WIDTH=32 and WIDTH=8.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_if #(.WIDTH(32)) bus32 ();
    mult_div_if #(.WIDTH(8))  bus8 ();

    mult_div_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    mult_div_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t model32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t               e;
        logic [63:0]        p;
        logic signed [31:0] sq;
        logic signed [31:0] sr;
        e.dbz = 1'b0;
        case (op)
            2'b00: begin
                p = 64'(a) * 64'(b);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = '1; e.dbz = 1'b1;
                end else begin
                    e.hi = a % b; e.lo = a / b;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi = a; e.lo = '1; e.dbz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'd0; e.lo = 32'h8000_0000;
                end else begin
                    sq = $signed(a) / $signed(b);
                    sr = $signed(a) % $signed(b);
                    e.hi = sr; e.lo = sq;
                end
            end
        endcase
        return e;
    endfunction

    // Drive one start cycle; the operands are scrambled right after acceptance.
    task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit push);
        bus32.start = 1'b1; bus32.op = op; bus32.a = a; bus32.b = b;
        if (push) q32.push_back(model32(op, a, b));
        @(posedge clk); #1;
        bus32.start = 1'b0; bus32.op = 2'($urandom); bus32.a = $urandom; bus32.b = $urandom;
    endtask

    task automatic issue8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
        @(posedge clk); #1;
        bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    endtask

    // Count cycles (and busy samples) until done, bounded.
    task automatic wait32(output int n, output int nbusy);
        n = 0;
        nbusy = bus32.busy ? 1 : 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (bus32.busy) nbusy++;
        end while (!bus32.done && n < 200);
    endtask

    task automatic wait8(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus8.done && n < 200);
    endtask

    task automatic test_reset;
        total++;
        if ({bus32.busy, bus32.done, bus32.div_by_zero, bus32.hi, bus32.lo} !== 67'd0) begin
            bad++;
            $display("FAIL reset32: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all zero",
                     bus32.busy, bus32.done, bus32.div_by_zero, bus32.hi, bus32.lo);
        end
        total++;
        if ({bus8.busy, bus8.done, bus8.div_by_zero, bus8.hi, bus8.lo} !== 19'd0) begin
            bad++;
            $display("FAIL reset8: got busy=%b done=%b dbz=%b hi=%h lo=%h, expected all zero",
                     bus8.busy, bus8.done, bus8.div_by_zero, bus8.hi, bus8.lo);
        end
    endtask

    task automatic test_multu_latency;
        int n, nb;
        exp_t e;
        issue32(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        wait32(n, nb);
        total++;
        if (n !== 33) begin bad++; $display("FAIL multu latency: got %0d expected 33", n); end
        total++;
        if (nb !== 33) begin bad++; $display("FAIL multu busy cycles: got %0d expected 33", nb); end
        e = q32.pop_front();
        total++;
        if ({bus32.hi, bus32.lo, bus32.div_by_zero} !== {e.hi, e.lo, e.dbz} ||
            {bus32.hi, bus32.lo} !== 64'hFFFF_FFFE_0000_0001) begin
            bad++;
            $display("FAIL multu result: got hi=%h lo=%h expected hi=fffffffe lo=00000001", bus32.hi, bus32.lo);
        end
    endtask

    task automatic test_start_while_busy;
        int n, nb, extra;
        exp_t e;
        issue32(2'b01, 32'hFFFF_FFFD, 32'd7, 1);
        repeat (5) begin @(posedge clk); #1; end
        bus32.start = 1'b1; bus32.op = 2'b00; bus32.a = 32'd1; bus32.b = 32'd1;
        @(posedge clk); #1;
        bus32.start = 1'b0;
        wait32(n, nb);
        total++;
        if (n !== 27) begin bad++; $display("FAIL busy-start latency: got %0d expected 27", n); end
        e = q32.pop_front();
        total++;
        if ({bus32.hi, bus32.lo, bus32.div_by_zero} !== {e.hi, e.lo, e.dbz} ||
            {bus32.hi, bus32.lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            bad++;
            $display("FAIL mult result: got hi=%h lo=%h dbz=%b expected hi=ffffffff lo=ffffffeb dbz=0",
                     bus32.hi, bus32.lo, bus32.div_by_zero);
        end
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (bus32.done || bus32.busy) extra++; end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL ignored start: got %0d busy/done cycles expected 0", extra); end
    endtask

    task automatic test_back_to_back;
        int n, nb;
        exp_t e;
        issue32(2'b10, 32'd7, 32'd2, 1);
        wait32(n, nb);
        e = q32.pop_front();
        total++;
        if ({bus32.hi, bus32.lo, bus32.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
            bad++;
            $display("FAIL divu result: got hi=%h lo=%h expected hi=%h lo=%h", bus32.hi, bus32.lo, e.hi, e.lo);
        end
        issue32(2'b11, 32'hFFFF_FFF9, 32'd2, 1);
        total++;
        if ({bus32.busy, bus32.done} !== 2'b10) begin
            bad++;
            $display("FAIL back-to-back accept: got busy=%b done=%b expected busy=1 done=0", bus32.busy, bus32.done);
        end
        wait32(n, nb);
        total++;
        if (n !== 33) begin bad++; $display("FAIL div latency: got %0d expected 33", n); end
        e = q32.pop_front();
        total++;
        if ({bus32.hi, bus32.lo, bus32.div_by_zero} !== {e.hi, e.lo, e.dbz} ||
            {bus32.hi, bus32.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
            bad++;
            $display("FAIL div result: got hi=%h lo=%h expected hi=ffffffff lo=fffffffd", bus32.hi, bus32.lo);
        end
    endtask

    task automatic test_div_by_zero;
        int n, nb;
        exp_t e;
        issue32(2'b10, 32'h0000_1234, 32'd0, 1);
        wait32(n, nb);
        total++;
        if (n !== 33) begin bad++; $display("FAIL dbz latency: got %0d expected 33", n); end
        e = q32.pop_front();
        total++;
        if ({bus32.hi, bus32.lo, bus32.div_by_zero} !== {e.hi, e.lo, e.dbz} ||
            {bus32.hi, bus32.lo, bus32.div_by_zero} !== {64'h0000_1234_FFFF_FFFF, 1'b1}) begin
            bad++;
            $display("FAIL dbz result: got hi=%h lo=%h dbz=%b expected hi=00001234 lo=ffffffff dbz=1",
                     bus32.hi, bus32.lo, bus32.div_by_zero);
        end
        @(posedge clk); #1;
        total++;
        if ({bus32.done, bus32.div_by_zero} !== 2'b00) begin
            bad++;
            $display("FAIL dbz pulse: got done=%b dbz=%b expected 0 0", bus32.done, bus32.div_by_zero);
        end
        issue32(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait32(n, nb);
        e = q32.pop_front();
        total++;
        if ({bus32.hi, bus32.lo, bus32.div_by_zero} !== {e.hi, e.lo, e.dbz} ||
            {bus32.hi, bus32.lo, bus32.div_by_zero} !== {64'h0000_0000_8000_0000, 1'b0}) begin
            bad++;
            $display("FAIL min/-1 result: got hi=%h lo=%h dbz=%b expected hi=00000000 lo=80000000 dbz=0",
                     bus32.hi, bus32.lo, bus32.div_by_zero);
        end
    endtask

    task automatic test_reset_abort;
        int n, nb, extra;
        exp_t e;
        issue32(2'b01, 32'h0000_0123, 32'hFFFF_0042, 0);
        repeat (9) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({bus32.busy, bus32.done, bus32.hi, bus32.lo} !== 66'd0) begin
            bad++;
            $display("FAIL abort: got busy=%b done=%b hi=%h lo=%h expected all zero",
                     bus32.busy, bus32.done, bus32.hi, bus32.lo);
        end
        reset = 1'b0;
        extra = 0;
        repeat (40) begin @(posedge clk); #1; if (bus32.done) extra++; end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL abort done: got %0d done pulses expected 0", extra); end
        issue32(2'b00, 32'd6, 32'd7, 1);
        wait32(n, nb);
        e = q32.pop_front();
        total++;
        if ({bus32.hi, bus32.lo} !== {e.hi, e.lo} || bus32.lo !== 32'd42) begin
            bad++;
            $display("FAIL post-reset multu: got hi=%h lo=%h expected hi=0 lo=2a", bus32.hi, bus32.lo);
        end
    endtask

    task automatic test_random;
        int n, nb;
        logic [1:0]  op;
        logic [31:0] a, b;
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
            b  = (i % 4 == 3) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            issue32(op, a, b, 1);
            wait32(n, nb);
            e = q32.pop_front();
            total++;
            if (n !== 33 || {bus32.hi, bus32.lo, bus32.div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
                bad++;
                $display("FAIL random op=%0d a=%h b=%h: got lat=%0d hi=%h lo=%h dbz=%b expected lat=33 hi=%h lo=%h dbz=%b",
                         op, a, b, n, bus32.hi, bus32.lo, bus32.div_by_zero, e.hi, e.lo, e.dbz);
            end
        end
    endtask

    task automatic test_width8;
        int n;
        exp_t e;
        e.hi = 32'h40; e.lo = 32'h00; e.dbz = 1'b0;
        q8.push_back(e);
        issue8(2'b01, 8'h80, 8'h80);
        wait8(n);
        total++;
        if (n !== 9) begin bad++; $display("FAIL w8 latency: got %0d expected 9", n); end
        e = q8.pop_front();
        total++;
        if ({bus8.hi, bus8.lo, bus8.div_by_zero} !== {e.hi[7:0], e.lo[7:0], e.dbz}) begin
            bad++;
            $display("FAIL w8 mult: got hi=%h lo=%h expected hi=%h lo=%h", bus8.hi, bus8.lo, e.hi[7:0], e.lo[7:0]);
        end
        e.hi = 32'hF1; e.lo = 32'hF9; e.dbz = 1'b0;
        q8.push_back(e);
        issue8(2'b11, 8'h81, 8'h10);
        wait8(n);
        e = q8.pop_front();
        total++;
        if (n !== 9 || {bus8.hi, bus8.lo, bus8.div_by_zero} !== {e.hi[7:0], e.lo[7:0], e.dbz}) begin
            bad++;
            $display("FAIL w8 div: got lat=%0d hi=%h lo=%h expected lat=9 hi=%h lo=%h",
                     n, bus8.hi, bus8.lo, e.hi[7:0], e.lo[7:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus32.start = 1'b0; bus32.op = 2'b00; bus32.a = '0; bus32.b = '0;
        bus8.start  = 1'b0; bus8.op  = 2'b00; bus8.a  = '0; bus8.b  = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        @(posedge clk); #1;
        test_multu_latency();
        test_start_while_busy();
        test_back_to_back();
        test_div_by_zero();
        test_reset_abort();
        test_random();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
